// File: rtl/vga_pkg.sv
// Shared types and 1080p timing constants for the scan-out fetch scheduler.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VCMD = 3'd1,
    VDAT = 3'd2,
    HCMD = 3'd3,
    HDAT = 3'd4
  } state_e;

  localparam int H_VISIBLE_1080P  = 1920;
  localparam int V_VISIBLE_1080P  = 1080;
  localparam int V_TOTAL_1080P    = 1125;
  localparam int LINE_WORDS_1080P = 480;
  localparam int BURST_1080P      = 16;

endpackage

// File: rtl/vga_fetch_arbiter.sv
// Scan-out memory scheduler: prefetches the next visible line into a ping-pong
// line buffer in bursts and lets the host use the command port only in the gaps.
module vga_fetch_arbiter
  import vga_pkg::*;
#(
  parameter int HW         = 12,
  parameter int H_VISIBLE  = H_VISIBLE_1080P,
  parameter int V_VISIBLE  = V_VISIBLE_1080P,
  parameter int V_TOTAL    = V_TOTAL_1080P,
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int LINE_WORDS = LINE_WORDS_1080P,
  parameter int BURST      = BURST_1080P
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [HW-1:0] hdata,
  input  logic [HW-1:0] vdata,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_we,
  output logic [AW-1:0] cmd_addr,
  output logic [4:0]    cmd_len,
  output logic [DW-1:0] cmd_wdata,
  input  logic          rvalid,
  input  logic [DW-1:0] rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [8:0]    lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          overrun
);

  localparam int NBURST = LINE_WORDS / BURST;
  localparam int BIW    = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int BTW    = (BURST > 1) ? $clog2(BURST) : 1;

  state_e         state_q, state_d;
  logic           pend_q, pend_d;
  logic           overrun_q, overrun_d;
  logic           host_ack_q, host_ack_d;
  logic [BIW-1:0] burst_q, burst_d;
  logic [BTW-1:0] beat_q, beat_d;
  logic [AW-1:0]  base_q, base_d;
  logic           bank_q, bank_d;
  logic [DW-1:0]  host_rdata_q, host_rdata_d;

  logic [HW-1:0]  next_line;
  logic           trig;
  logic           pend_clr;

  // Detect the start of horizontal blanking ahead of a visible line.
  always_comb begin
    next_line = (vdata == HW'(V_TOTAL - 1)) ? '0 : vdata + HW'(1);
    trig      = (hdata == HW'(H_VISIBLE)) && (next_line < HW'(V_VISIBLE));
  end

  // Next-state, command port and line buffer strobes.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    pend_clr     = 1'b0;
    cmd_valid    = 1'b0;
    cmd_we       = 1'b0;
    cmd_addr     = base_q + AW'(int'(burst_q) * BURST);
    cmd_len      = 5'(BURST);
    cmd_wdata    = host_wdata;
    lb_we        = 1'b0;
    lb_addr      = 9'(int'(burst_q) * BURST + int'(beat_q));
    lb_wdata     = rdata;
    unique case (state_q)
      IDLE: begin
        // A pending line always wins; the ack guard stops a held request
        // from being reissued in the cycle its acknowledge is visible.
        if (pend_q)                       state_d = VCMD;
        else if (host_req && !host_ack_q) state_d = HCMD;
      end
      VCMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          beat_d  = '0;
          state_d = VDAT;
        end
      end
      VDAT: begin
        if (rvalid) begin
          lb_we  = 1'b1;
          beat_d = beat_q + BTW'(1);
          if (int'(beat_q) == BURST - 1) begin
            beat_d = '0;
            if (int'(burst_q) == NBURST - 1) begin
              burst_d  = '0;
              pend_clr = 1'b1;
              state_d  = IDLE;
            end else begin
              burst_d = burst_q + BIW'(1);
              state_d = VCMD;
            end
          end
        end
      end
      HCMD: begin
        cmd_valid = 1'b1;
        cmd_we    = host_we;
        cmd_addr  = host_addr;
        cmd_len   = 5'd1;
        if (cmd_ready) begin
          if (host_we) begin
            host_ack_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = HDAT;
          end
        end
      end
      HDAT: begin
        if (rvalid) begin
          host_rdata_d = rdata;
          host_ack_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line request bookkeeping: latch a new line or flag a dropped trigger.
  always_comb begin
    pend_d    = pend_q & ~pend_clr;
    overrun_d = overrun_q;
    base_d    = base_q;
    bank_d    = bank_q;
    if (trig) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        base_d = AW'(next_line * LINE_WORDS);
        bank_d = next_line[0];
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      overrun_q  <= 1'b0;
      host_ack_q <= 1'b0;
      burst_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
      host_ack_q <= host_ack_d;
      burst_q    <= (trig && !pend_q) ? '0 : burst_d;
      beat_q     <= beat_d;
    end
  end

  // Datapath registers; only meaningful once qualified by control state.
  always_ff @(posedge clk) begin
    base_q       <= base_d;
    bank_q       <= bank_d;
    host_rdata_q <= host_rdata_d;
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign lb_bank    = bank_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter with a simple in-order read memory model.
module tb_vga_fetch_arbiter;
  import vga_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] hdata, vdata;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [23:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        host_req, host_we;
  logic [23:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        lb_we, lb_bank;
  logic [8:0]  lb_addr;
  logic [31:0] lb_wdata;
  logic        overrun;

  int n_chk = 0;
  int n_err = 0;

  vga_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rvalid(rvalid), .rdata(rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reads answered in order, first beat on the third clock after accept.
  int          beats_left = 0;
  int          beat = 0;
  int          dly = 0;
  logic [23:0] raddr;
  always @(negedge clk) begin
    #2;
    rvalid = 1'b0;
    if (beats_left > 0) begin
      if (dly > 0) dly--;
      else begin
        rvalid = 1'b1;
        rdata  = (raddr == 24'h123) ? 32'h0000A5A5 : {8'hD0, 24'(raddr + 24'(beat))};
        beat++;
        beats_left--;
      end
    end
    if (cmd_valid && cmd_ready && !cmd_we) begin
      raddr      = cmd_addr;
      beats_left = int'(cmd_len);
      beat       = 0;
      dly        = 2;
    end
  end

  // Monitor: log accepted commands, count line-buffer writes and bad writes.
  logic [23:0] q_addr[$];
  logic [4:0]  q_len[$];
  logic        q_we[$];
  logic [31:0] q_wd[$];
  int          lb_cnt = 0;
  int          lb_err = 0;
  int          ack_cnt = 0;
  int          exp_base = 0;
  logic        exp_bank = 1'b0;
  always @(negedge clk) begin
    #3;
    if (cmd_valid && cmd_ready) begin
      q_addr.push_back(cmd_addr);
      q_len.push_back(cmd_len);
      q_we.push_back(cmd_we);
      q_wd.push_back(cmd_wdata);
    end
    if (lb_we) begin
      lb_cnt++;
      if (lb_wdata !== {8'hD0, 24'(exp_base + int'(lb_addr))} || lb_bank !== exp_bank ||
          lb_addr >= 9'd480)
        lb_err++;
    end
    if (host_ack) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #4;
  endtask

  task automatic fire(input int v);
    @(negedge clk);
    vdata = 12'(v);
    hdata = 12'd1920;
    @(negedge clk);
    hdata = 12'd0;
  endtask

  task automatic wait_lb(input int target, input string tag);
    int n = 0;
    while (lb_cnt < target && n < 4000) begin
      sample();
      n++;
    end
    chk(tag, 64'(lb_cnt >= target), 1);
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    while (!host_ack && n < 4000) begin
      sample();
      n++;
    end
    chk(tag, 64'(host_ack), 1);
  endtask

  // Fetch one line and check all 30 burst commands plus the 480 buffer writes.
  task automatic line_test(input int v, input int base, input logic bank,
                           input string tag, input bit sweep);
    int q0, l0, e0, bad;
    exp_base = base;
    exp_bank = bank;
    q0 = q_addr.size();
    l0 = lb_cnt;
    e0 = lb_err;
    if (sweep) begin
      for (int h = 1915; h <= 1922; h++) begin
        @(negedge clk);
        vdata = 12'(v);
        hdata = 12'(h);
      end
      @(negedge clk);
      hdata = 12'd0;
    end else begin
      fire(v);
    end
    wait_lb(l0 + 480, {tag, "_done"});
    repeat (4) sample();
    chk({tag, "_ncmd"}, 64'(q_addr.size() - q0), 30);
    bad = 0;
    if (q_addr.size() >= q0 + 30) begin
      chk({tag, "_addr_first"}, 64'(q_addr[q0]), 64'(base));
      chk({tag, "_addr_last"}, 64'(q_addr[q0 + 29]), 64'(base + 464));
      for (int k = 0; k < 30; k++)
        if (q_addr[q0 + k] != 24'(base + 16 * k) || q_len[q0 + k] != 5'd16 || q_we[q0 + k])
          bad++;
    end
    chk({tag, "_burst_fields"}, 64'(bad), 0);
    chk({tag, "_lb_we"}, 64'(lb_cnt - l0), 480);
    chk({tag, "_lb_data"}, 64'(lb_err - e0), 0);
    chk({tag, "_idle"}, 64'(cmd_valid), 0);
  endtask

  initial begin
    int q0, l0, a0, n;
    rst_n = 1'b0; hdata = '0; vdata = '0; cmd_ready = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_cmd_valid", 64'(cmd_valid), 0);
    chk("rst_host_ack", 64'(host_ack), 0);
    chk("rst_lb_we", 64'(lb_we), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Line 1 from the hdata sweep on line 0, then frame wrap to line 0.
    line_test(0, 480, 1'b1, "line1", 1'b1);
    line_test(1124, 0, 1'b0, "line0", 1'b0);

    // Last visible line: no further fetch.
    q0 = q_addr.size();
    fire(1079);
    repeat (20) sample();
    chk("nofetch_ncmd", 64'(q_addr.size() - q0), 0);

    // Host write arriving mid-line waits for the whole line.
    exp_base = 960; exp_bank = 1'b0;
    q0 = q_addr.size(); l0 = lb_cnt; a0 = ack_cnt;
    fire(1);
    wait_lb(l0 + 1, "hw_vdat");
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 24'h55; host_wdata = 32'hDEADBEEF;
    wait_ack("hw_ack", n);
    chk("hw_lines_done", 64'(lb_cnt - l0), 480);
    @(negedge clk);
    host_req = 1'b0;
    repeat (4) sample();
    chk("hw_ncmd", 64'(q_addr.size() - q0), 31);
    if (q_addr.size() >= q0 + 31) begin
      chk("hw_addr", 64'(q_addr[q0 + 30]), 64'h55);
      chk("hw_len", 64'(q_len[q0 + 30]), 1);
      chk("hw_we", 64'(q_we[q0 + 30]), 1);
      chk("hw_wdata", 64'(q_wd[q0 + 30]), 64'hDEADBEEF);
    end
    chk("hw_ack_once", 64'(ack_cnt - a0), 1);

    // Host read with data three clocks after the command.
    q0 = q_addr.size();
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 24'h123;
    wait_ack("hr_ack", n);
    chk("hr_latency", 64'(n), 5);
    chk("hr_rdata", 64'(host_rdata), 64'hA5A5);
    @(negedge clk);
    host_req = 1'b0;
    repeat (3) sample();
    chk("hr_ncmd", 64'(q_addr.size() - q0), 1);
    if (q_addr.size() >= q0 + 1) begin
      chk("hr_addr", 64'(q_addr[q0]), 64'h123);
      chk("hr_len_we", 64'({q_len[q0], q_we[q0]}), 64'({5'd1, 1'b0}));
    end

    // Stalled command port across the next trigger.
    exp_base = 2880; exp_bank = 1'b0;
    q0 = q_addr.size(); l0 = lb_cnt;
    @(negedge clk);
    cmd_ready = 1'b0;
    fire(5);
    repeat (3) sample();
    chk("ov_stall_valid", 64'(cmd_valid), 1);
    chk("ov_stall_addr", 64'(cmd_addr), 2880);
    chk("ov_before", 64'(overrun), 0);
    fire(6);
    repeat (2) sample();
    chk("ov_set", 64'(overrun), 1);
    chk("ov_addr_stable", 64'(cmd_addr), 2880);
    @(negedge clk);
    cmd_ready = 1'b1;
    wait_lb(l0 + 480, "ov_done");
    repeat (10) sample();
    chk("ov_sticky", 64'(overrun), 1);
    chk("ov_ncmd", 64'(q_addr.size() - q0), 30);
    chk("ov_no_restart", 64'(cmd_valid), 0);

    // Reset in the middle of a burst.
    exp_base = 4800; exp_bank = 1'b0;
    l0 = lb_cnt;
    fire(9);
    wait_lb(l0 + 7, "rb_vdat");
    @(negedge clk);
    rst_n = 1'b0;
    sample();
    chk("rb_cmd_valid", 64'(cmd_valid), 0);
    chk("rb_lb_we", 64'(lb_we), 0);
    chk("rb_overrun", 64'(overrun), 0);
    chk("rb_state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    l0 = lb_cnt;
    repeat (40) sample();
    chk("rb_beats_ignored", 64'(lb_cnt - l0), 0);
    chk("rb_stay_idle", 64'(cmd_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
